// File: rtl/i1_status_seq.sv
// rtl/i1_status_seq.sv - debounced request-idle status encoder with valid/ready delivery
module i1_status_seq #(
  parameter int N_REQ = 7,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             force_busy,
  input  logic             mode_a,
  input  logic [N_REQ-1:0] req,
  input  logic             clear,
  input  logic             code_ready,
  output logic [1:0]       code_out,
  output logic             code_valid,
  output logic             idle_q,
  output logic             overrun,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [N_REQ-1:0] req_seen
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [1:0] CODE_OFF    = 2'b00;
  localparam logic [1:0] CODE_IDLE_A = 2'b01;
  localparam logic [1:0] CODE_BUSY   = 2'b10;
  localparam logic [1:0] CODE_IDLE_B = 2'b11;

  localparam logic [7:0]       HOLD_C  = 8'(HOLD);
  localparam logic [7:0]       HOLD_M1 = 8'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state_q;
  logic [1:0] last_q;
  logic [7:0] hold_q, hold_d;
  logic       idle_d;
  logic       raw_idle;
  logic [1:0] code_d;
  logic       changed;

  assign raw_idle   = enable & (req == '0);
  assign code_valid = (state_q == FULL);
  assign changed    = (code_d != last_q);

  // idle_d looks one count ahead so idle_q rises on the HOLD-th idle edge
  always_comb begin
    hold_d = 8'd0;
    idle_d = 1'b0;
    if (raw_idle) begin
      hold_d = (hold_q < HOLD_C) ? hold_q + 8'd1 : hold_q;
      idle_d = (hold_q >= HOLD_M1);
    end
  end

  always_comb begin
    code_d = CODE_BUSY;
    if (!enable)         code_d = CODE_OFF;
    else if (force_busy) code_d = CODE_BUSY;
    else if (idle_q)     code_d = mode_a ? CODE_IDLE_A : CODE_IDLE_B;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      code_out <= CODE_OFF;
      last_q   <= CODE_OFF;
      overrun  <= 1'b0;
    end else begin
      if (clear) overrun <= 1'b0;
      case (state_q)
        EMPTY: begin
          if (changed) begin
            code_out <= code_d;
            last_q   <= code_d;
            state_q  <= FULL;
          end
        end
        FULL: begin
          if (code_ready) begin
            if (changed) begin
              code_out <= code_d;
              last_q   <= code_d;
            end else begin
              state_q  <= EMPTY;
            end
          end else if (changed) begin
            // stalled: keep presenting the old code, remember that one was lost
            overrun <= 1'b1;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q   <= 8'd0;
      idle_q   <= 1'b0;
      xfer_cnt <= '0;
      req_seen <= '0;
    end else begin
      hold_q <= hold_d;
      idle_q <= idle_d;
      if (clear)
        xfer_cnt <= '0;
      else if (code_valid && code_ready && (xfer_cnt != CNT_MAX))
        xfer_cnt <= xfer_cnt + 1'b1;
      req_seen <= clear ? req : (req_seen | req);
    end
  end

endmodule

// File: doc/i1_status_seq.md
Name: i1_status_seq

Overview:
- Parametrised, clocked successor to the combinational i1 status-decode benchmark.
- Watches N_REQ request lines under an enable qualifier, debounces the all-idle condition over HOLD cycles and encodes a 2-bit status code.
- Delivers each status change through a valid/ready handshake, with overrun detection, a transfer counter and sticky per-request capture.
- Sits between the request/mode inputs and the downstream status consumer.

Parameters:
N_REQ, 7, number of request lines monitored
HOLD, 4, consecutive idle cycles required before idle is declared (legal range 1..255)
CNT_W, 8, width of the saturating transfer counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  qualifies the whole block; 0 forces status OFF
force_busy  input  1  overrides idle and forces status BUSY
mode_a  input  1  selects the IDLE_A or IDLE_B encoding
req  input  N_REQ  request lines; all zero means idle
clear  input  1  synchronous clear of the counter, overrun flag and req_seen
code_ready  input  1  consumer accepts code_out
code_out  output  2  status code being presented
code_valid  output  1  code_out is valid
idle_q  output  1  debounced all-idle flag
overrun  output  1  sticky: status changed while a transfer was stalled
xfer_cnt  output  CNT_W  accepted transfers, saturating
req_seen  output  N_REQ  sticky OR of req bits since the last clear

Behaviour:
- Reset (async, active-high) forces: code_out=00, code_valid=0, idle_q=0, overrun=0, xfer_cnt=0, req_seen=0, hold counter=0, last_sent=00.
- raw_idle = enable & (req == 0).
- Hold counter, width 8:
  - Increments while raw_idle=1 and the count is below HOLD.
  - Forced to 0 when raw_idle=0.
  - idle_q is registered. It rises on the edge after raw_idle has been 1 for HOLD consecutive cycles, and falls on the first edge where raw_idle=0.
  - With HOLD=1, idle_q follows raw_idle delayed by one cycle.
- Next-status code (combinational from inputs and idle_q), in priority order:
  - enable=0 -> 00 OFF.
  - force_busy=1 -> 10 BUSY.
  - idle_q=1 and mode_a=1 -> 01 IDLE_A.
  - idle_q=1 and mode_a=0 -> 11 IDLE_B.
  - otherwise -> 10 BUSY.
- Handshake FSM, states EMPTY (code_valid=0) and FULL (code_valid=1):
  - EMPTY: if next code != last_sent, load code_out and last_sent with it and go to FULL on the same edge. Latency from the input change to code_valid is one cycle.
  - FULL: if code_ready=1, the transfer is accepted. If next code != last_sent on that same edge, load it and stay FULL (back-to-back). Otherwise go to EMPTY.
  - FULL with code_ready=0: code_out and code_valid hold. If next code differs from last_sent, set overrun. The newest code is sent after acceptance; intermediate codes are dropped.
  - code_out never changes while code_valid=1 and code_ready=0.
- xfer_cnt increments on each code_valid & code_ready edge and saturates at 2^CNT_W-1 (no wrap).
- clear:
  - Zeroes xfer_cnt, overrun and req_seen on the next edge.
  - Clear beats an increment on the same edge.
  - For req_seen, a set beats clear: req_seen <= req when clear=1.
  - An overrun event coincident with clear leaves overrun=1.
  - clear does not affect the FSM, code_out or idle_q.
- req_seen <= req_seen | req each cycle when clear=0.
- Reset asserted mid-transfer aborts it: code_valid drops immediately (async). After release, a non-OFF status is re-sent as a new transfer.

Test Plan:
- Reset release with enable=0, req=0 -> code_valid stays 0, code_out=00 (next code equals last_sent).
- enable=1, req=7'h00 held, mode_a=1, code_ready=1 -> BUSY 10 is sent first. idle_q rises 4 cycles after enable. One cycle later code_out=01 and code_valid=1 for one cycle. xfer_cnt=2.
- Idle established, code_ready=0, then req=7'h10 -> code_out stays 01 and overrun=1. After code_ready=1: 01 accepted, then 10 sent back-to-back. req_seen=7'h10.
- force_busy=1 while idle_q=1 -> code 10. Release with mode_a=0 -> code 11 one cycle later.
- CNT_W=2: accept 5 transfers -> xfer_cnt=3 (saturated). Pulse clear while an accept happens -> xfer_cnt=0. Pulse clear with req=7'h01 -> req_seen=7'h01.
- Assert reset while code_valid=1 and code_ready=0 -> all outputs return to reset values immediately, without a clock edge.
